// File: rtl/dp_grant_seq.sv
// Grant sequencer for the dual-priority encoder path.
// Turns an accepted (first, second) code pair into back-to-back one-hot grants.
module dp_grant_seq #(
  parameter int NREQ = 12,
  parameter int CW   = 4,
  parameter int HOLD = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CW-1:0]   first,
  input  logic [CW-1:0]   second,
  input  logic            rel,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_valid,
  output logic            done,
  output logic            err
);

  localparam int CNTW = $clog2(HOLD + 1);

  typedef enum logic [1:0] {
    IDLE,
    CHK,
    GNT1,
    GNT2
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   first_q;
  logic [CW-1:0]   second_q;
  logic [CNTW-1:0] cnt_q;
  logic [NREQ-1:0] gnt_q;
  logic            gv_q;
  logic            done_q;
  logic            err_q;

  logic f_ok;
  logic s_ok;
  logic pair_ok;
  logic last;

  function automatic logic [NREQ-1:0] onehot(
    input logic [CW-1:0] c
  );
    logic [NREQ-1:0] v;
    v = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (c == CW'(i + 1)) v[i] = 1'b1;
    end
    return v;
  endfunction

  assign f_ok = (first_q <= CW'(NREQ));
  assign s_ok = (second_q <= CW'(NREQ));

  assign pair_ok = f_ok && s_ok &&
    ((first_q == '0 && second_q == '0) ||
     (first_q != '0 && second_q < first_q));

  // rel cuts the current phase short exactly like counter expiry
  assign last = rel || (cnt_q == CNTW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      first_q  <= '0;
      second_q <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      gv_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            first_q  <= first;
            second_q <= second;
            state_q  <= CHK;
          end
        end
        CHK: begin
          if (!pair_ok) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else if (first_q == '0) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            gnt_q   <= onehot(first_q);
            gv_q    <= 1'b1;
            cnt_q   <= CNTW'(HOLD);
            state_q <= GNT1;
          end
        end
        GNT1: begin
          if (last && second_q != '0) begin
            gnt_q   <= onehot(second_q);
            cnt_q   <= CNTW'(HOLD);
            state_q <= GNT2;
          end else if (last) begin
            gnt_q   <= '0;
            gv_q    <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNTW'(1);
          end
        end
        GNT2: begin
          if (last) begin
            gnt_q   <= '0;
            gv_q    <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNTW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign gnt       = gnt_q;
  assign gnt_valid = gv_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dp_grant_seq.sv
// Bench for dp_grant_seq: vector table, per-cycle scoreboard,
// plus backpressure and mid-grant reset sequences.
module tb_dp_grant_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  first;
  logic [3:0]  second;
  logic        rel;
  logic [11:0] gnt;
  logic        gnt_valid;
  logic        done;
  logic        err;

  int total;
  int bad;

  typedef struct {
    int          f;
    int          s;
    int          r;
    logic [11:0] g1;
    int          n1;
    logic [11:0] g2;
    int          n2;
    bit          er;
  } vec_t;

  typedef struct packed {
    logic [11:0] g;
    logic        gv;
    logic        dn;
    logic        er;
    logic        rdy;
  } obs_t;

  obs_t sbq[$];
  vec_t tbl[13];

  dp_grant_seq #(
    .NREQ(12),
    .CW  (4),
    .HOLD(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .first    (first),
    .second   (second),
    .rel      (rel),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] sample();
    return {gnt, gnt_valid, done, err, in_ready};
  endfunction

  task automatic run_pair(input string nm, input vec_t v,
                          input bit bp, input int rst_at);
    obs_t e;
    int   j;
    first    = 4'(v.f);
    second   = 4'(v.s);
    in_valid = 1'b1;
    check({nm, " ready_pre"}, 16'(in_ready), 16'h1);
    sbq.push_back('{12'h0, 1'b0, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < v.n1; i++)
      sbq.push_back('{v.g1, 1'b1, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < v.n2; i++)
      sbq.push_back('{v.g2, 1'b1, 1'b0, 1'b0, 1'b0});
    sbq.push_back('{12'h0, 1'b0, !v.er, v.er, 1'b1});
    @(posedge clk);
    #1;
    if (!bp) in_valid = 1'b0;
    j = 0;
    while (sbq.size() > 0) begin
      @(negedge clk);
      j++;
      e = sbq.pop_front();
      check($sformatf("%s c%0d", nm, j), sample(), e);
      rel = (j == v.r);
      if (bp && sbq.size() > 0) begin
        first    = 4'($urandom_range(15));
        second   = 4'($urandom_range(15));
        in_valid = 1'b1;
      end
      if (rst_at == j) begin
        rst_n = 1'b0;
        #1;
        check({nm, " rst_async"}, sample(), 16'h0001);
        sbq.delete();
        rel = 1'b0;
      end
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    first    = '0;
    second   = '0;
    rel      = 1'b0;

    tbl[0]  = '{12, 11, 0, 12'h800, 4, 12'h400, 4, 1'b0};
    tbl[1]  = '{ 2,  0, 0, 12'h002, 4, 12'h000, 0, 1'b0};
    tbl[2]  = '{ 0,  0, 0, 12'h000, 0, 12'h000, 0, 1'b0};
    tbl[3]  = '{13,  1, 0, 12'h000, 0, 12'h000, 0, 1'b1};
    tbl[4]  = '{ 3,  5, 0, 12'h000, 0, 12'h000, 0, 1'b1};
    tbl[5]  = '{ 0,  1, 0, 12'h000, 0, 12'h000, 0, 1'b1};
    tbl[6]  = '{12,  1, 3, 12'h800, 2, 12'h001, 4, 1'b0};
    tbl[7]  = '{ 1,  0, 0, 12'h001, 4, 12'h000, 0, 1'b0};
    tbl[8]  = '{ 5,  5, 0, 12'h000, 0, 12'h000, 0, 1'b1};
    tbl[9]  = '{14,  0, 0, 12'h000, 0, 12'h000, 0, 1'b1};
    tbl[10] = '{ 7,  3, 6, 12'h040, 4, 12'h004, 1, 1'b0};
    tbl[11] = '{ 9,  0, 2, 12'h100, 1, 12'h000, 0, 1'b0};
    tbl[12] = '{ 4,  2, 1, 12'h008, 4, 12'h002, 4, 1'b0};

    #1;
    check("reset_state", sample(), 16'h0001);
    repeat (3) @(negedge clk);
    check("reset_hold", sample(), 16'h0001);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++)
      run_pair($sformatf("vec%0d", i), tbl[i], 1'b0, 0);

    run_pair("bp_full", tbl[0], 1'b1, 0);
    run_pair("bp_next", tbl[7], 1'b0, 0);

    run_pair("rst_mid", tbl[0], 1'b0, 7);
    repeat (2) begin
      @(negedge clk);
      check("rst_low", sample(), 16'h0001);
    end
    rst_n = 1'b1;
    run_pair("after_rst", tbl[7], 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dp_grant_seq.md
# dp_grant_seq

Grant sequencer for the 12-request dual-priority encoder path, consuming the encoder's (first, second) code pair. It accepts one pair per valid/ready handshake, checks it for legality, and decodes each 4-bit code to a one-hot 12-bit grant. It then issues the grants one after the other: highest priority first, then second priority, each held for a programmable number of cycles. It sits downstream of the dual-priority encoder and drives the requester grant lines.

## Interface
- NREQ, 12, number of request/grant lines; codes 1..NREQ map to grant bit code-1
- CW, 4, code width; must satisfy 2**CW > NREQ
- HOLD, 4, cycles each grant is asserted (>= 1); counter width $clog2(HOLD+1)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  code pair valid
- in_ready  output  1  block can accept a pair; high only in IDLE
- first  input  CW  highest-priority code; 0 = no request
- second  input  CW  second-priority code; 0 = none
- rel  input  1  early release of the current grant phase
- gnt  output  NREQ  one-hot grant, registered; all-zero when no grant
- gnt_valid  output  1  registered; high whenever gnt is non-zero
- done  output  1  one-cycle pulse when a legal pair has fully completed
- err  output  1  one-cycle pulse when an illegal pair was accepted and dropped

## Operation
- Reset: asynchronous, active-low, immediate.
  - Values during and after reset: state IDLE, gnt=0, gnt_valid=0, done=0, err=0, hold counter 0.
  - in_ready = (state==IDLE), so it reads 1 during reset.
- Accept: a pair is captured on a rising edge with in_valid && in_ready. in_valid outside IDLE is ignored, and the pair is not queued.
- Code legality: 0 = none; 1..NREQ = valid; NREQ+1..2**CW-1 (13..15) = illegal.
- Pair legality: both codes legal, and one of the following holds:
  - first==0 && second==0, or
  - first!=0 && second < first (second==0 allowed).
  - Anything else is illegal, e.g. second >= first with second != 0, or first==0 with second != 0.
- States:
  - IDLE → CHK on accept; codes are registered.
  - CHK is a one-cycle decision state, no grant. Exits:
    - illegal pair: err=1 next cycle, → IDLE;
    - first==0: done=1 next cycle, → IDLE;
    - otherwise → GNT1.
  - GNT1: gnt = 1<<(first-1) for HOLD cycles. Then:
    - if second!=0 → GNT2;
    - else → IDLE with done=1.
  - GNT2: gnt = 1<<(second-1) for HOLD cycles, then → IDLE with done=1.
- rel:
  - High in any GNT1/GNT2 cycle, that cycle is the last cycle of that phase; the next phase or completion follows exactly as on counter expiry.
  - Ignored in IDLE and CHK.
- Grant phases are back-to-back: GNT1→GNT2 has no zero cycle, and gnt changes directly from one one-hot value to the other.
- done and err are mutually exclusive and never coincide with gnt_valid.

## Timing
- Accept edge is k.
  - CHK occupies cycle k+1.
  - GNT1 occupies cycles k+2 .. k+HOLD+1.
  - GNT2 occupies cycles k+HOLD+2 .. k+2*HOLD+1.
- done is high in the first IDLE cycle after the final phase. in_ready is also high that cycle, so a new pair can be accepted at the end of it.
- Two-grant pair: accept-to-done = 2*HOLD+2 cycles.
- One-grant pair: accept-to-done = HOLD+2 cycles.
- Empty pair (0,0): done at k+2.
- Illegal pair: err at k+2.
- HOLD=1: one cycle per grant.
- Reset mid-operation:
  - gnt, gnt_valid, done and err clear asynchronously.
  - The pending pair is discarded, with no done or err for it.
  - First accept is possible on the first edge after rst_n rises.

## Test plan
- Full pair, HOLD=4: first=4'b1100, second=4'b1011.
  - -> gnt=12'h800 for 4 cycles (k+2..k+5), then 12'h400 for 4 cycles (k+6..k+9).
  - -> done at k+10; gnt_valid high continuously k+2..k+9.
- Single grant: first=4'b0010, second=0 -> gnt=12'h002 for 4 cycles, done at k+6, no second grant.
- Empty and illegal pairs, each -> gnt stays 0:
  - (0,0) -> done at k+2, err stays 0;
  - (13,1) -> err at k+2, no done;
  - (3,5) -> err at k+2, no done;
  - (0,1) -> err at k+2, no done.
- Early release: first=12, second=1, rel pulsed at k+3 -> gnt=12'h800 at k+2..k+3, then 12'h001 at k+4..k+7, done at k+8.
- Backpressure: in_valid held high with changing codes during GNT1/GNT2 -> in_ready=0 and no capture. The next pair is accepted only at the done cycle edge.
- Reset mid-GNT2: rst_n low at k+7 -> gnt=0 immediately and no done. After rst_n rises, in_ready=1 and a new pair (1,0) yields gnt=12'h001.
